// File: rtl/mmu_feeder_pkg.sv
// Shared types and sizing for the matrix-multiply-unit input feeder.
// Array geometry, pipeline latency and the tile sequencing state enum live here.
package mmu_feeder_pkg;

    localparam int DIM    = 16;
    localparam int DW     = 8;
    localparam int VW     = DIM * DW;
    localparam int PE_LAT = 1;
    localparam int ROW_W  = $clog2(DIM);
    localparam int DRN_W  = $clog2(PE_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN
    } state_t;

    typedef logic [VW-1:0] vec_t;

    // Saturating increment for the performance counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mmu_feeder_dly.sv
// Fixed-depth shift register that tracks {valid,last} alongside the array's
// result pipeline; every stage clears on reset.
module mmu_feeder_dly #(
    parameter int DEPTH = 1,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [DEPTH-1:0][W-1:0] stage_q;
    logic [DEPTH-1:0][W-1:0] stage_d;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign stage_d[gi] = din;
        end else begin : g_tail
            assign stage_d[gi] = stage_q[gi-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/mmu_feeder.sv
// Tile sequencer feeding the 16x16 matrix multiply array: weight rows, then activations.
// Optional performance counters are built only when MMU_FEEDER_PERF_EN is defined.
module mmu_feeder
    import mmu_feeder_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_start,
    input  logic          cmd_keep_w,
    input  logic          w_valid,
    output logic          w_ready,
    input  logic [VW-1:0] w_data,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [VW-1:0] a_data,
    input  logic          a_last,
    output logic          mmu_wen,
    output logic [VW-1:0] mmu_win,
    output logic          mmu_en,
    output logic [VW-1:0] mmu_ain,
    output logic          res_valid,
    output logic          res_last,
    output logic          busy,
    output logic          done,
    output logic [31:0]   perf_act_cnt,
    output logic [31:0]   perf_stall
);

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [DRN_W-1:0] drain_q, drain_d;
    logic             wen_q, wen_d;
    logic             en_q, en_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic [VW-1:0]    win_q, win_d;
    logic [VW-1:0]    ain_q, ain_d;
    logic             start_acc;
    logic             a_acc;
    logic [1:0]       res_bits;

    // A start arriving in the done cycle belongs to the finishing tile and is dropped.
    assign start_acc = (state_q == IDLE) && cmd_start && !done_q;
    assign a_acc     = (state_q == STREAM) && a_valid;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        drain_d = drain_q;
        wen_d   = 1'b0;
        en_d    = 1'b0;
        last_d  = 1'b0;
        done_d  = 1'b0;
        win_d   = win_q;
        ain_d   = ain_q;
        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    row_d   = '0;
                    state_d = cmd_keep_w ? STREAM : LOAD_W;
                end
            end
            LOAD_W: begin
                if (w_valid) begin
                    wen_d = 1'b1;
                    win_d = w_data;
                    if (row_q == ROW_W'(DIM - 1)) begin
                        row_d   = '0;
                        state_d = STREAM;
                    end else begin
                        row_d = ROW_W'(row_q + 1);
                    end
                end
            end
            STREAM: begin
                if (a_valid) begin
                    en_d   = 1'b1;
                    ain_d  = a_data;
                    last_d = a_last;
                    if (a_last) begin
                        drain_d = '0;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Hold until the final vector's result has left the array.
                if (drain_q == DRN_W'(PE_LAT)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = DRN_W'(drain_q + 1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            drain_q <= '0;
            wen_q   <= 1'b0;
            en_q    <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            win_q   <= '0;
            ain_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            drain_q <= drain_d;
            wen_q   <= wen_d;
            en_q    <= en_d;
            last_q  <= last_d;
            done_q  <= done_d;
            win_q   <= win_d;
            ain_q   <= ain_d;
        end
    end

    mmu_feeder_dly #(
        .DEPTH (PE_LAT),
        .W     (2)
    ) u_dly (
        .clk   (clk),
        .reset (reset),
        .din   ({en_q, en_q & last_q}),
        .dout  (res_bits)
    );

    assign w_ready   = (state_q == LOAD_W);
    assign a_ready   = (state_q == STREAM);
    assign busy      = (state_q != IDLE);
    assign mmu_wen   = wen_q;
    assign mmu_win   = win_q;
    assign mmu_en    = en_q;
    assign mmu_ain   = ain_q;
    assign res_valid = res_bits[1];
    assign res_last  = res_bits[0];
    assign done      = done_q;

`ifdef MMU_FEEDER_PERF_EN
    logic [31:0] act_q, act_d;
    logic [31:0] stall_q, stall_d;

    always_comb begin
        act_d   = act_q;
        stall_d = stall_q;
        if (start_acc) begin
            act_d   = '0;
            stall_d = '0;
        end else begin
            if (a_acc) begin
                act_d = sat_inc(act_q);
            end
            if (((state_q == LOAD_W) && !w_valid) || ((state_q == STREAM) && !a_valid)) begin
                stall_d = sat_inc(stall_q);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_q   <= '0;
            stall_q <= '0;
        end else begin
            act_q   <= act_d;
            stall_q <= stall_d;
        end
    end

    assign perf_act_cnt = act_q;
    assign perf_stall   = stall_q;
`else
    assign perf_act_cnt = 32'd0;
    assign perf_stall   = 32'd0;
`endif

endmodule

// File: tb/tb_mmu_feeder.sv
// Self-checking bench for mmu_feeder: directed tiles plus a transaction-level
// model that predicts enables, data, result flags and done on every cycle.
module tb_mmu_feeder;
    import mmu_feeder_pkg::*;

    logic          clk;
    logic          reset;
    logic          cmd_start, cmd_keep_w;
    logic          w_valid, w_ready;
    logic [VW-1:0] w_data;
    logic          a_valid, a_ready, a_last;
    logic [VW-1:0] a_data;
    logic          mmu_wen, mmu_en;
    logic [VW-1:0] mmu_win, mmu_ain;
    logic          res_valid, res_last, busy, done;
    logic [31:0]   perf_act_cnt, perf_stall;

    mmu_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_start    (cmd_start),
        .cmd_keep_w   (cmd_keep_w),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_data       (w_data),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_data       (a_data),
        .a_last       (a_last),
        .mmu_wen      (mmu_wen),
        .mmu_win      (mmu_win),
        .mmu_en       (mmu_en),
        .mmu_ain      (mmu_ain),
        .res_valid    (res_valid),
        .res_last     (res_last),
        .busy         (busy),
        .done         (done),
        .perf_act_cnt (perf_act_cnt),
        .perf_stall   (perf_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int errs  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model state and per-tile observation logs
    int          cyc = 0;
    logic        pw_acc = 1'b0, pa_acc = 1'b0, pa_last = 1'b0;
    vec_t        pw_data, pa_data;
    logic [PE_LAT-1:0] pipe_v = '0, pipe_l = '0;
    logic        exp_done = 1'b0;
    int          wen_cnt, en_cnt, res_cnt, res_last_cnt, res_last_idx, done_cnt;
    int          wen_first, wen_last, en_cyc, done_cyc;
    logic        w_ready_seen;
    vec_t        wlog[$];

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            pw_acc   = 1'b0;
            pa_acc   = 1'b0;
            pipe_v   = '0;
            pipe_l   = '0;
            exp_done = 1'b0;
            chk("rst_ctl", {busy, w_ready, a_ready, mmu_wen, mmu_en, res_valid, res_last, done}, 0);
            chk("rst_win", mmu_win, 0);
            chk("rst_ain", mmu_ain, 0);
            chk("rst_perf", {perf_act_cnt, perf_stall}, 0);
        end else begin
            chk("wen", mmu_wen, pw_acc);
            if (pw_acc) chk("win", mmu_win, pw_data);
            if (mmu_wen) begin
                wlog.push_back(mmu_win);
                if (wen_cnt == 0) wen_first = cyc;
                wen_last = cyc;
                wen_cnt++;
            end
            chk("en", mmu_en, pa_acc);
            if (pa_acc) chk("ain", mmu_ain, pa_data);
            if (mmu_en) begin
                en_cnt++;
                en_cyc = cyc;
            end
            chk("overlap", mmu_wen & mmu_en, 0);
            chk("rdy_not_busy", (w_ready | a_ready) & ~busy, 0);
            chk("res_valid", res_valid, pipe_v[PE_LAT-1]);
            chk("res_last", res_last, pipe_l[PE_LAT-1]);
            if (res_valid) res_cnt++;
            if (res_last) begin
                res_last_cnt++;
                res_last_idx = res_cnt;
            end
            chk("done", done, exp_done);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (w_ready) w_ready_seen = 1'b1;
`ifndef MMU_FEEDER_PERF_EN
            chk("perf_off", {perf_act_cnt, perf_stall}, 0);
`endif
            exp_done = pipe_l[PE_LAT-1];
            pipe_v   = (pipe_v << 1) | PE_LAT'(pa_acc);
            pipe_l   = (pipe_l << 1) | PE_LAT'(pa_acc & pa_last);
            pw_acc   = w_valid & w_ready;
            pw_data  = w_data;
            pa_acc   = a_valid & a_ready;
            pa_data  = a_data;
            pa_last  = a_last;
        end
    end

    task automatic clear_logs();
        wen_cnt = 0; en_cnt = 0; res_cnt = 0; res_last_cnt = 0; res_last_idx = 0;
        done_cnt = 0; wen_first = 0; wen_last = 0; en_cyc = 0; done_cyc = 0;
        w_ready_seen = 1'b0;
        wlog.delete();
    endtask

    // All drive tasks start and end at posedge+1.
    task automatic start(input logic keep);
        cmd_start = 1'b1;
        cmd_keep_w = keep;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        cmd_keep_w = 1'b0;
    endtask

    task automatic send_w(input vec_t d);
        w_valid = 1'b1;
        w_data  = d;
        @(negedge clk);
        chk("w_ready_load", w_ready, 1);
        @(posedge clk); #1;
        w_valid = 1'b0;
    endtask

    task automatic send_a(input vec_t d, input logic last);
        a_valid = 1'b1;
        a_data  = d;
        a_last  = last;
        @(negedge clk);
        chk("a_ready_stream", a_ready, 1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        a_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done();
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_seen", done, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cmd_start = 0; cmd_keep_w = 0;
        w_valid = 0; w_data = '0;
        a_valid = 0; a_data = '0; a_last = 0;
        clear_logs();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(1);

        // Full tile: 16 rows back to back, 4 vectors
        clear_logs();
        start(1'b0);
        chk("t1_busy", busy, 1);
        for (int k = 0; k < DIM; k++) send_w({DIM{k[7:0]}});
        chk("t1_w_ready_off", w_ready, 0);
        chk("t1_a_ready_on", a_ready, 1);
        for (int k = 0; k < 4; k++) send_a({DIM{k[7:0] + 8'h11}}, k == 3);
        wait_done();
        idle(1);
        chk("t1_wen_cnt", wen_cnt, 16);
        chk("t1_wen_span", wen_last - wen_first, 15);
        for (int k = 0; k < DIM; k++) chk("t1_row_order", wlog[k], {DIM{k[7:0]}});
        chk("t1_row0", wlog[0], 128'h0);
        chk("t1_row15", wlog[15], 128'h0F0F0F0F_0F0F0F0F_0F0F0F0F_0F0F0F0F);
        chk("t1_en_cnt", en_cnt, 4);
        chk("t1_res_cnt", res_cnt, 4);
        chk("t1_res_last_cnt", res_last_cnt, 1);
        chk("t1_res_last_idx", res_last_idx, 4);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_idle", busy, 0);

        // Backpressure: w_valid toggling 1,0,1,...
        clear_logs();
        start(1'b0);
        for (int k = 0; k < DIM; k++) begin
            send_w({DIM{k[7:0] + 8'hA0}});
            idle(1);
        end
        chk("t2_w_ready_off", w_ready, 0);
        chk("t2_wen_cnt", wen_cnt, 16);
        chk("t2_wen_span", wen_last - wen_first, 30);
        for (int k = 0; k < DIM; k++) chk("t2_row_order", wlog[k], {DIM{k[7:0] + 8'hA0}});
        send_a({DIM{8'h5A}}, 1'b1);
        wait_done();
`ifdef MMU_FEEDER_PERF_EN
        chk("t2_perf_act", perf_act_cnt, 1);
        chk("t2_perf_stall", perf_stall, 16);
`endif

        // Keep weights, start while busy, single-vector tile, start in done cycle
        clear_logs();
        start(1'b1);
        chk("t3_a_ready", a_ready, 1);
        chk("t3_w_ready", w_ready, 0);
        cmd_start = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        chk("t3_ignore_a", a_ready, 1);
        chk("t3_ignore_w", w_ready, 0);
        send_a({DIM{8'hC3}}, 1'b1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (res_last) break;
        end
        chk("t3_res_last_seen", res_last, 1);
        @(posedge clk); #1;
        cmd_start = 1'b1;
        @(negedge clk);
        chk("t3_done_pulse", done, 1);
        @(posedge clk); #1;
        cmd_start = 1'b0;
        @(negedge clk);
        chk("t3_start_in_done_ignored", busy, 0);
        chk("t3_done_lat", done_cyc - en_cyc, PE_LAT + 1);
        chk("t3_no_wen", wen_cnt, 0);
        chk("t3_no_w_ready", w_ready_seen, 0);
        chk("t3_res_cnt", res_cnt, 1);
        chk("t3_res_last_cnt", res_last_cnt, 1);
        @(posedge clk); #1;

        // Reset mid-LOAD_W after 7 rows
        clear_logs();
        start(1'b0);
        for (int k = 0; k < 7; k++) send_w({DIM{k[7:0] + 8'h30}});
        #2 reset = 1'b1;
        #1;
        chk("t4_async_ctl", {busy, w_ready, mmu_wen}, 0);
        chk("t4_async_win", mmu_win, 0);
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(1);
        clear_logs();
        start(1'b0);
        for (int k = 0; k < DIM; k++) send_w({DIM{k[7:0] + 8'h40}});
        chk("t4_w_ready_off", w_ready, 0);
        chk("t4_a_ready_on", a_ready, 1);
        send_a({DIM{8'h01}}, 1'b0);
        send_a({DIM{8'h02}}, 1'b1);
        wait_done();
        idle(1);
        chk("t4_wen_cnt", wen_cnt, 16);
        chk("t4_row0", wlog[0], {DIM{8'h40}});
        chk("t4_done_cnt", done_cnt, 1);

        // Performance counters: 10 vectors with 3 idle cycles
        clear_logs();
        start(1'b1);
        for (int k = 0; k < 10; k++) begin
            send_a({DIM{k[7:0]}}, k == 9);
            if (k == 2 || k == 5 || k == 8) idle(1);
        end
        wait_done();
        idle(1);
        chk("t5_en_cnt", en_cnt, 10);
`ifdef MMU_FEEDER_PERF_EN
        chk("t5_perf_act", perf_act_cnt, 10);
        chk("t5_perf_stall", perf_stall, 3);
`else
        chk("t5_perf_act_off", perf_act_cnt, 0);
        chk("t5_perf_stall_off", perf_stall, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
